// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl: loads a word onto a 16:1 mux tree, walks the select,
// serialises the sampled output and checks the reassembled word.
module mux16_scan_ctrl #(
  parameter int DWELL     = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic [15:0] mux_i,
  output logic [3:0]  mux_s,
  input  logic        mux_y,
  output logic        ser_valid,
  output logic        ser_bit,
  output logic        ser_last,
  input  logic        ser_ready,
  output logic        busy,
  output logic        word_valid,
  output logic [15:0] word_out,
  output logic        word_err
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PRESENT,
    DONE
  } state_e;

  localparam logic [3:0] DW_LAST = 4'(DWELL - 1);
  localparam logic [3:0] S_FIRST = LSB_FIRST ? 4'd0 : 4'd15;

  state_e      state_q;
  logic [3:0]  dwell_q;
  logic [3:0]  bit_q;
  logic        in_ready_q;
  logic [15:0] mux_i_q;
  logic [3:0]  mux_s_q;
  logic [3:0]  mux_s_d;
  logic        ser_valid_q;
  logic        ser_bit_q;
  logic        ser_last_q;
  logic        busy_q;
  logic        word_valid_q;
  logic [15:0] word_out_q;
  logic        word_err_q;

  // Next select position in scan order.
  always_comb begin
    mux_s_d = LSB_FIRST ? mux_s_q + 4'd1 : mux_s_q - 4'd1;
  end

  // Scan sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dwell_q      <= '0;
      bit_q        <= '0;
      in_ready_q   <= 1'b0;
      mux_i_q      <= '0;
      mux_s_q      <= '0;
      ser_valid_q  <= 1'b0;
      ser_bit_q    <= 1'b0;
      ser_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      word_valid_q <= 1'b0;
      word_out_q   <= '0;
      word_err_q   <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            mux_i_q    <= in_data;
            mux_s_q    <= S_FIRST;
            dwell_q    <= '0;
            bit_q      <= '0;
            word_out_q <= '0;
            word_err_q <= 1'b0;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          dwell_q <= dwell_q + 4'd1;
          if (dwell_q == DW_LAST) begin
            ser_bit_q           <= mux_y;
            word_out_q[mux_s_q] <= mux_y;
            ser_valid_q         <= 1'b1;
            ser_last_q          <= (bit_q == 4'd15);
            state_q             <= PRESENT;
          end
        end
        PRESENT: begin
          if (ser_ready) begin
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            if (bit_q == 4'd15) begin
              word_valid_q <= 1'b1;
              word_err_q   <= (word_out_q != mux_i_q);
              state_q      <= DONE;
            end else begin
              mux_s_q <= mux_s_d;
              bit_q   <= bit_q + 4'd1;
              dwell_q <= '0;
              state_q <= SETTLE;
            end
          end
        end
        DONE: begin
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mux_i      = mux_i_q;
  assign mux_s      = mux_s_q;
  assign ser_valid  = ser_valid_q;
  assign ser_bit    = ser_bit_q;
  assign ser_last   = ser_last_q;
  assign busy       = busy_q;
  assign word_valid = word_valid_q;
  assign word_out   = word_out_q;
  assign word_err   = word_err_q;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb_mux16_scan_ctrl: two controller instances (forward/dwell 1 and
// reverse/dwell 3) driving behavioural mux trees.
module tb_mux16_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic ser_ready = 1'b1;
  logic fault = 1'b0;
  bit sel = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic rdy0, sv0, sb0, sl0, bz0, wv0, we0, y0;
  logic rdy1, sv1, sb1, sl1, bz1, wv1, we1, y1;
  logic [15:0] mi0, wo0, mi1, wo1;
  logic [3:0] ms0, ms1;

  always #5 clk = ~clk;

  assign y0 = mi0[ms0] & ~(fault && ms0 == 4'd0);
  assign y1 = mi1[ms1];

  mux16_scan_ctrl #(.DWELL(1), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && !sel), .in_ready(rdy0), .in_data(in_data),
    .mux_i(mi0), .mux_s(ms0), .mux_y(y0),
    .ser_valid(sv0), .ser_bit(sb0), .ser_last(sl0), .ser_ready(ser_ready),
    .busy(bz0), .word_valid(wv0), .word_out(wo0), .word_err(we0)
  );

  mux16_scan_ctrl #(.DWELL(3), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && sel), .in_ready(rdy1), .in_data(in_data),
    .mux_i(mi1), .mux_s(ms1), .mux_y(y1),
    .ser_valid(sv1), .ser_bit(sb1), .ser_last(sl1), .ser_ready(ser_ready),
    .busy(bz1), .word_valid(wv1), .word_out(wo1), .word_err(we1)
  );

  logic o_rdy, o_sv, o_sb, o_sl, o_bz, o_wv, o_we;
  logic [15:0] o_mi, o_wo;
  logic [3:0] o_ms;
  logic [42:0] o_all;

  assign o_rdy = sel ? rdy1 : rdy0;
  assign o_sv  = sel ? sv1 : sv0;
  assign o_sb  = sel ? sb1 : sb0;
  assign o_sl  = sel ? sl1 : sl0;
  assign o_bz  = sel ? bz1 : bz0;
  assign o_wv  = sel ? wv1 : wv0;
  assign o_we  = sel ? we1 : we0;
  assign o_mi  = sel ? mi1 : mi0;
  assign o_wo  = sel ? wo1 : wo0;
  assign o_ms  = sel ? ms1 : ms0;
  assign o_all = {o_rdy, o_mi, o_ms, o_sv, o_sb, o_sl,
                  o_bz, o_wv, o_wo, o_we};

  // Observations of one scan
  int obs_wv_cyc, obs_wv_cnt, obs_first, obs_stalls;
  logic [15:0] obs_word;
  logic obs_err;
  logic obs_bits[$];
  logic [3:0] obs_s[$];
  logic obs_last[$];
  int obs_cyc[$];
  logic stall_bit[$];
  logic [3:0] stall_s[$];
  int stall_nb[$];
  logic [15:0] obs_mi[$];

  // Reference model: scan order and expected sampled bit
  function automatic logic [3:0] exp_idx(input bit which, input int k);
    return which ? 4'(15 - k) : 4'(k);
  endfunction

  function automatic logic exp_bit(input logic [15:0] w,
                                   input logic [3:0] idx,
                                   input bit flt);
    return w[idx] & ~(flt && idx == 4'd0);
  endfunction

  function automatic int dwell_of(input bit which);
    return which ? 3 : 1;
  endfunction

  // Load a word and record everything observed until word_valid.
  task automatic drive_scan(input bit which, input logic [15:0] w,
                            input int st_beat, input int st_len,
                            input int rnd_pct, input bit junk,
                            input int stop_after);
    int cyc, nb, stl, budget;
    bit done;
    obs_wv_cyc = -1; obs_wv_cnt = 0; obs_first = -1; obs_stalls = 0;
    obs_word = 'x; obs_err = 1'bx;
    obs_bits.delete(); obs_s.delete(); obs_last.delete();
    obs_cyc.delete(); stall_bit.delete(); stall_s.delete();
    stall_nb.delete(); obs_mi.delete();
    sel = which;
    #1;
    budget = 0;
    while (!o_rdy && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!o_rdy) return;
    in_valid = 1'b1; in_data = w; ser_ready = 1'b1;
    cyc = 0; nb = 0; stl = 0; done = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (junk && cyc >= 3 && cyc < 20) begin
        in_valid = 1'b1; in_data = ~w;
      end else begin
        in_valid = 1'b0;
      end
      obs_mi.push_back(o_mi);
      if (o_wv) begin
        obs_wv_cnt++;
        if (obs_wv_cyc < 0) begin
          obs_wv_cyc = cyc; obs_word = o_wo; obs_err = o_we;
        end
      end
      if (o_sv && obs_first < 0) obs_first = cyc;
      if (o_sv) begin
        if (nb == st_beat && stl < st_len) begin
          ser_ready = 1'b0; stl++;
        end else if (rnd_pct > 0 && $urandom_range(99) < rnd_pct) begin
          ser_ready = 1'b0;
        end else begin
          ser_ready = 1'b1;
        end
        if (!ser_ready) begin
          obs_stalls++;
          stall_bit.push_back(o_sb);
          stall_s.push_back(o_ms);
          stall_nb.push_back(nb);
        end else begin
          obs_bits.push_back(o_sb);
          obs_s.push_back(o_ms);
          obs_last.push_back(o_sl);
          obs_cyc.push_back(cyc);
          nb++;
          if (stop_after > 0 && nb == stop_after) done = 1'b1;
        end
      end else begin
        ser_ready = 1'($urandom_range(1));
      end
      if (obs_wv_cyc >= 0 && cyc >= obs_wv_cyc + 2) done = 1'b1;
    end
    in_valid = 1'b0;
    ser_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = bit'(d); #1;
      n_cmp++;
      if (o_all !== '0) begin
        n_err++;
        $display("FAIL reset_init dut%0d outputs=%h exp 0", d, o_all);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = bit'(d); #1;
      n_cmp++;
      if ({o_rdy, o_bz} !== 2'b10) begin
        n_err++;
        $display("FAIL reset_release dut%0d rdy,busy=%b exp 10", d,
                 {o_rdy, o_bz});
      end
    end
    @(negedge clk);
    drive_scan(1'b1, 16'($urandom), -1, 0, 0, 1'b0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = bit'(d); #1;
      n_cmp++;
      if (o_all !== '0) begin
        n_err++;
        $display("FAIL reset_mid dut%0d outputs=%h exp 0", d, o_all);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    sel = 1'b1; #1;
    n_cmp++;
    if ({o_rdy, o_bz} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_mid_release rdy,busy=%b exp 10", {o_rdy, o_bz});
    end
  endtask

  task automatic test_basic();
    logic [15:0] w;
    int bad;
    w = 16'h4F6F;
    drive_scan(1'b0, w, -1, 0, 0, 1'b0, 0);
    n_cmp++;
    if (obs_bits.size() != 16) begin
      n_err++;
      $display("FAIL basic_beats got %0d exp 16", obs_bits.size());
    end
    for (int k = 0; k < obs_bits.size(); k++) begin
      n_cmp++;
      if ({obs_bits[k], obs_s[k], obs_last[k]} !==
          {exp_bit(w, exp_idx(0, k), 0), exp_idx(0, k), k == 15}) begin
        n_err++;
        $display("FAIL basic_beat%0d bit,s,last=%b,%0d,%b exp %b,%0d,%b",
                 k, obs_bits[k], obs_s[k], obs_last[k],
                 exp_bit(w, exp_idx(0, k), 0), exp_idx(0, k), k == 15);
      end
    end
    n_cmp++;
    if (obs_first != 2) begin
      n_err++;
      $display("FAIL basic_first_valid cyc %0d exp 2", obs_first);
    end
    n_cmp++;
    if ({obs_wv_cyc, obs_wv_cnt, obs_word, obs_err} !==
        {32'sd33, 32'sd1, w, 1'b0}) begin
      n_err++;
      $display("FAIL basic_word cyc=%0d n=%0d word=%h err=%b exp 33 1 %h 0",
               obs_wv_cyc, obs_wv_cnt, obs_word, obs_err, w);
    end
    bad = 0;
    foreach (obs_mi[k]) if (obs_mi[k] !== w) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL basic_mux_i %0d cycles differ from %h", bad, w);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w;
    w = 16'h4F6F;
    drive_scan(1'b0, w, 3, 5, 0, 1'b0, 0);
    n_cmp++;
    if (stall_bit.size() != 5) begin
      n_err++;
      $display("FAIL bp_stalls got %0d exp 5", stall_bit.size());
    end
    foreach (stall_bit[k]) begin
      n_cmp++;
      if ({stall_bit[k], stall_s[k], 32'(stall_nb[k])} !==
          {1'b1, 4'd3, 32'd3}) begin
        n_err++;
        $display("FAIL bp_hold%0d bit=%b s=%0d beat=%0d exp 1 3 3",
                 k, stall_bit[k], stall_s[k], stall_nb[k]);
      end
    end
    for (int k = 0; k < obs_bits.size(); k++) begin
      n_cmp++;
      if ({obs_bits[k], obs_s[k]} !==
          {exp_bit(w, exp_idx(0, k), 0), exp_idx(0, k)}) begin
        n_err++;
        $display("FAIL bp_beat%0d bit=%b s=%0d", k, obs_bits[k], obs_s[k]);
      end
    end
    n_cmp++;
    if ({obs_wv_cyc, obs_word, obs_err} !== {32'sd38, w, 1'b0}) begin
      n_err++;
      $display("FAIL bp_word cyc=%0d word=%h err=%b exp 38 %h 0",
               obs_wv_cyc, obs_word, obs_err, w);
    end
  endtask

  task automatic test_fault();
    logic [15:0] w;
    w = 16'h4F6F;
    fault = 1'b1;
    drive_scan(1'b0, w, -1, 0, 0, 1'b0, 0);
    fault = 1'b0;
    n_cmp++;
    if (obs_bits.size() != 16 || obs_bits[0] !== 1'b0) begin
      n_err++;
      $display("FAIL fault_first_bit beats=%0d exp 16 with bit0=0",
               obs_bits.size());
    end
    n_cmp++;
    if ({obs_wv_cyc, obs_word, obs_err} !== {32'sd33, 16'h4F6E, 1'b1}) begin
      n_err++;
      $display("FAIL fault_word cyc=%0d word=%h err=%b exp 33 4f6e 1",
               obs_wv_cyc, obs_word, obs_err);
    end
  endtask

  task automatic test_reverse();
    logic [15:0] w;
    w = 16'h8001;
    drive_scan(1'b1, w, -1, 0, 0, 1'b0, 0);
    n_cmp++;
    if (obs_bits.size() != 16) begin
      n_err++;
      $display("FAIL rev_beats got %0d exp 16", obs_bits.size());
    end
    for (int k = 0; k < obs_bits.size(); k++) begin
      n_cmp++;
      if ({obs_bits[k], obs_s[k], obs_last[k], 32'(obs_cyc[k])} !==
          {exp_bit(w, exp_idx(1, k), 0), exp_idx(1, k), k == 15,
           32'(4 * (k + 1))}) begin
        n_err++;
        $display("FAIL rev_beat%0d bit=%b s=%0d last=%b cyc=%0d exp s=%0d cyc=%0d",
                 k, obs_bits[k], obs_s[k], obs_last[k], obs_cyc[k],
                 exp_idx(1, k), 4 * (k + 1));
      end
    end
    n_cmp++;
    if ({obs_wv_cyc, obs_word, obs_err} !== {32'sd65, w, 1'b0}) begin
      n_err++;
      $display("FAIL rev_word cyc=%0d word=%h err=%b exp 65 %h 0",
               obs_wv_cyc, obs_word, obs_err, w);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    bit which;
    int bad, exp_cyc;
    for (int r = 0; r < 8; r++) begin
      which = 1'($urandom_range(1));
      w = 16'($urandom);
      drive_scan(which, w, -1, 0, 30, 1'b0, 0);
      bad = (obs_bits.size() != 16) ? 1 : 0;
      for (int k = 0; k < obs_bits.size(); k++)
        if ({obs_bits[k], obs_s[k], obs_last[k]} !==
            {exp_bit(w, exp_idx(which, k), 0), exp_idx(which, k), k == 15})
          bad++;
      foreach (stall_bit[k])
        if ({stall_bit[k], stall_s[k]} !==
            {exp_bit(w, exp_idx(which, stall_nb[k]), 0),
             exp_idx(which, stall_nb[k])})
          bad++;
      n_cmp++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL rnd%0d_stream dut%0d word %h: %0d bad beats",
                 r, which, w, bad);
      end
      exp_cyc = 16 * (dwell_of(which) + 1) + 1 + obs_stalls;
      n_cmp++;
      if ({obs_wv_cyc, obs_wv_cnt, obs_word, obs_err} !==
          {exp_cyc, 32'sd1, w, 1'b0}) begin
        n_err++;
        $display("FAIL rnd%0d_word cyc=%0d n=%0d word=%h err=%b exp %0d 1 %h 0",
                 r, obs_wv_cyc, obs_wv_cnt, obs_word, obs_err, exp_cyc, w);
      end
    end
  endtask

  task automatic test_abort();
    int wvs, bad;
    logic [15:0] w;
    drive_scan(1'b0, 16'($urandom), -1, 0, 0, 1'b0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_all !== '0) begin
      n_err++;
      $display("FAIL abort_reset outputs=%h exp 0", o_all);
    end
    @(negedge clk); rst_n = 1'b1;
    wvs = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_wv) wvs++;
    end
    n_cmp++;
    if (wvs != 0) begin
      n_err++;
      $display("FAIL abort_no_word got %0d pulses exp 0", wvs);
    end
    w = 16'hA5A5;
    drive_scan(1'b0, w, -1, 0, 0, 1'b1, 0);
    bad = 0;
    foreach (obs_mi[k]) if (obs_mi[k] !== w) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL abort_busy_ignore mux_i changed in %0d cycles", bad);
    end
    n_cmp++;
    if ({obs_wv_cyc, obs_wv_cnt, obs_word, obs_err} !==
        {32'sd33, 32'sd1, w, 1'b0}) begin
      n_err++;
      $display("FAIL abort_reload cyc=%0d n=%0d word=%h err=%b exp 33 1 a5a5 0",
               obs_wv_cyc, obs_wv_cnt, obs_word, obs_err);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_fault();
    test_reverse();
    test_random();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux16_scan_ctrl.md
# mux16_scan_ctrl

Sequencing controller that drives the 16:1 structural mux tree (`mux_16x1`). It accepts a 16-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the 4-bit select through all 16 positions, samples the mux output and emits the result as a serial bit stream with backpressure. After the last bit it reassembles the word and flags any mismatch against the word it loaded, so the mux tree can be checked in-system.

## Interface
- `DWELL`, default 1: cycles the select is held before sampling `mux_y`; legal range 1..16.
- `LSB_FIRST`, default 1: 1 = select order 0→15; 0 = select order 15→0.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  `in_data` is offered.
- `in_ready`  out  1  controller accepts a word this cycle.
- `in_data`  in  16  word to scan.
- `mux_i`  out  16  data bus to the mux `i` input.
- `mux_s`  out  4  select to the mux `s` input.
- `mux_y`  in  1  mux output; combinational from `mux_i`/`mux_s`.
- `ser_valid`  out  1  `ser_bit` is valid.
- `ser_bit`  out  1  sampled mux output.
- `ser_last`  out  1  marks the 16th bit; qualified by `ser_valid`.
- `ser_ready`  in  1  downstream accepts `ser_bit`.
- `busy`  out  1  high in any state except IDLE.
- `word_valid`  out  1  one-cycle pulse; `word_out` and `word_err` are valid.
- `word_out`  out  16  reassembled word; bit k = sample taken at `mux_s`=k.
- `word_err`  out  1  `word_out` != latched input word.

## Operation
- States: IDLE, SETTLE, PRESENT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_data` into `mux_i`.
  - Set `mux_s` = 0 (LSB_FIRST) or 15, dwell counter = 0, bit counter = 0 → SETTLE.
- **SETTLE**
  - Dwell counter increments each cycle.
  - At the cycle with counter == DWELL-1: register `mux_y` into `ser_bit` and into `word_out[mux_s]` → PRESENT.
- **PRESENT**
  - `ser_valid`=1; `ser_last`=1 when bit counter == 15.
  - Beat accepted when `ser_ready`=1.
  - Accepted, not last: advance `mux_s` (±1), bit counter +1, dwell counter = 0 → SETTLE.
  - Accepted, last → DONE.
  - `ser_ready`=0: hold all outputs and `mux_s`.
- **DONE**
  - `word_valid`=1 for one cycle; `word_err` = (`word_out` != latched word) → IDLE.
- `in_valid` is ignored outside IDLE; `in_ready`=0 there.
- `mux_i` is held constant from load until the next load, including through IDLE.
- `mux_s` changes only on the PRESENT→SETTLE edge or on load.
- `word_out` is cleared on load. It holds its value after DONE until the next load.
- Reset (any time, async): state IDLE, all outputs 0, including `in_ready` while `rst_n`=0. No `word_valid` is issued for an aborted word. `in_ready`=1 from the first cycle after release.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `mux_y` is sampled DWELL cycles after `mux_s` settles. This allows for the mux tree delay.
- With `ser_ready` held at 1:
  - Each bit takes DWELL+1 cycles.
  - First `ser_valid` appears DWELL+1 cycles after the load edge.
  - `word_valid` appears in cycle 16·(DWELL+1)+1 counted from the load edge (cycle 0).
- Backpressure adds exactly one cycle per stalled cycle. Bits are never dropped or duplicated.
- A new word can be accepted in the cycle after `word_valid`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-simulation → all outputs 0, `busy`=0. After release, `in_ready`=1 next cycle.
- **Basic scan:** DWELL=1, LSB_FIRST=1, `ser_ready`=1, load 16'h4F6F.
  - `ser_bit` sequence: 1,1,1,1,0,1,1,0,1,1,1,1,0,0,1,0.
  - `ser_last` on the 16th beat.
  - `word_valid` at cycle 33 with `word_out`=16'h4F6F, `word_err`=0.
- **Backpressure:** same word, `ser_ready`=0 for 5 cycles while the bit at index 3 is presented.
  - `ser_bit`=1 and `mux_s`=3 are stable throughout the stall.
  - `word_valid` moves to cycle 38; word still 16'h4F6F.
- **Fault detect:** mux model with `y` stuck-at-0 when s=0, load 16'h4F6F → `word_out`=16'h4F6E, `word_err`=1.
- **Reverse order:** LSB_FIRST=0, DWELL=3, load 16'h8001.
  - `mux_s` steps 15→0; first bit is 1, last bit is 1.
  - Each bit spans 4 cycles; `word_valid` at cycle 65.
- **Abort:** pulse `rst_n` low after the 5th accepted bit.
  - No `word_valid` follows.
  - A following load of 16'hA5A5 completes with `word_out`=16'hA5A5, `word_err`=0.
  - `in_valid` asserted while busy is ignored.
